fetch_stage: RTL and testbench

Instruction-fetch stage of the P7 MIPS pipeline. Holds the architectural F-stage PC, drives the external instruction-memory address and detects fetch address exceptions (AdEL). Registers the fetched instruction into the F/D pipeline register under stall, flush and exception-entry control. Consumes the next-PC value from the next-PC unit and feeds D-stage decode and the CP0 delay-slot/exception tracking chain.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/fetch_stage_fd_reg.sv | 47 ++++
 rtl/fetch_stage.sv | 70 +++++++
 tb/tb_fetch_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared P7 CPU definitions: exception codes, default address map and
// the F/D pipeline-register payload used by the fetch stage.
package cpu_pkg;

   localparam logic [4:0]  EXC_NONE = 5'd0;
   localparam logic [4:0]  EXC_ADEL = 5'd4;

   localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
   localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
   localparam logic [31:0] IMEM_LO_DEFAULT    = 32'h0000_3000;
   localparam logic [31:0] IMEM_HI_DEFAULT    = 32'h0000_6FFC;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  exc_code;
      logic        bd;
   } fd_t;

   // Selected update action for the F/D register on the next edge.
   typedef enum logic [1:0] {
      FD_REQ,
      FD_HOLD,
      FD_FLUSH,
      FD_LOAD
   } fd_sel_e;

   function automatic logic fetch_adel(input logic [31:0] pc,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
      return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
   endfunction

   function automatic fd_t fd_bubble(input logic [31:0] pc);
      fd_t b;
      b.pc       = pc;
      b.instr    = NOP_INSTR;
      b.exc_code = EXC_NONE;
      b.bd       = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/fetch_stage_fd_reg.sv
// F/D pipeline register: reset > req > stall > flush > load priority.
module fd_reg
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic req_i,
   input  logic stall_i,
   input  logic flush_i,
   input  fd_t  f_i,
   output fd_t  d_o
);

   fd_t     fd_q;
   fd_t     fd_d;
   fd_sel_e sel;

   always_comb begin
      if (req_i)        sel = FD_REQ;
      else if (stall_i) sel = FD_HOLD;
      else if (flush_i) sel = FD_FLUSH;
      else              sel = FD_LOAD;
   end

   // A flushed slot keeps the F-stage PC so the bubble is still traceable.
   always_comb begin
      fd_d = fd_q;
      case (sel)
         FD_REQ:   fd_d = fd_bubble(HANDLER_PC);
         FD_HOLD:  fd_d = fd_q;
         FD_FLUSH: fd_d = fd_bubble(f_i.pc);
         FD_LOAD:  fd_d = f_i;
         default:  fd_d = fd_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) fd_q <= fd_bubble(RESET_PC);
      else       fd_q <= fd_d;
   end

   assign d_o = fd_q;

endmodule

// File: rtl/fetch_stage.sv
// P7 instruction-fetch stage: F-stage PC, AdEL detection and F/D register.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT,
   parameter logic [31:0] IMEM_LO    = IMEM_LO_DEFAULT,
   parameter logic [31:0] IMEM_HI    = IMEM_HI_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] npc,
   input  logic        stall,
   input  logic        flush,
   input  logic        req,
   input  logic        D_is_jump,
   output logic [31:0] i_inst_addr,
   input  logic [31:0] i_inst_rdata,
   output logic [31:0] D_pc,
   output logic [31:0] D_instr,
   output logic [4:0]  D_exc_code,
   output logic        D_bd
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic        f_adel;
   fd_t         f_fd;
   fd_t         d_fd;

   // req must override stall: the handler address arrives through npc.
   always_comb begin
      pc_d = npc;
      if (!req && stall) pc_d = pc_q;
   end

   always_ff @(posedge clk) begin
      if (reset) pc_q <= RESET_PC;
      else       pc_q <= pc_d;
   end

   assign i_inst_addr = pc_q;
   assign f_adel      = fetch_adel(pc_q, IMEM_LO, IMEM_HI);

   always_comb begin
      f_fd.pc       = pc_q;
      f_fd.bd       = D_is_jump;
      f_fd.instr    = f_adel ? NOP_INSTR : i_inst_rdata;
      f_fd.exc_code = f_adel ? EXC_ADEL  : EXC_NONE;
   end

   fd_reg #(
      .RESET_PC   (RESET_PC),
      .HANDLER_PC (HANDLER_PC)
   ) u_fd_reg (
      .clk     (clk),
      .reset   (reset),
      .req_i   (req),
      .stall_i (stall),
      .flush_i (flush),
      .f_i     (f_fd),
      .d_o     (d_fd)
   );

   assign D_pc       = d_fd.pc;
   assign D_instr    = d_fd.instr;
   assign D_exc_code = d_fd.exc_code;
   assign D_bd       = d_fd.bd;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a behavioural model.
module tb_fetch_stage;

   localparam logic [31:0] R_PC  = 32'h0000_3000;
   localparam logic [31:0] H_PC  = 32'h0000_4180;
   localparam logic [31:0] LO    = 32'h0000_3000;
   localparam logic [31:0] HI    = 32'h0000_6FFC;
   localparam logic [31:0] SALT  = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] npc = '0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        req = 1'b0;
   logic        D_is_jump = 1'b0;
   logic [31:0] i_inst_addr;
   logic [31:0] i_inst_rdata;
   logic [31:0] D_pc;
   logic [31:0] D_instr;
   logic [4:0]  D_exc_code;
   logic        D_bd;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // reference model state
   logic [31:0] m_fpc;
   logic [31:0] m_dpc;
   logic [31:0] m_dinstr;
   logic [4:0]  m_dexc;
   logic        m_dbd;

   always #5 clk = ~clk;

   assign i_inst_rdata = i_inst_addr ^ SALT;

   fetch_stage #(
      .RESET_PC   (R_PC),
      .HANDLER_PC (H_PC),
      .IMEM_LO    (LO),
      .IMEM_HI    (HI)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .npc          (npc),
      .stall        (stall),
      .flush        (flush),
      .req          (req),
      .D_is_jump    (D_is_jump),
      .i_inst_addr  (i_inst_addr),
      .i_inst_rdata (i_inst_rdata),
      .D_pc         (D_pc),
      .D_instr      (D_instr),
      .D_exc_code   (D_exc_code),
      .D_bd         (D_bd)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic bad_addr(input logic [31:0] a);
      return (a % 4 != 0) || (a < LO) || (a > HI);
   endfunction

   // Apply one cycle of inputs, advance the model, then compare after the edge.
   task automatic step(input logic r, input logic [31:0] n, input logic s,
                       input logic f, input logic q, input logic j);
      logic [31:0] fetched;
      reset = r; npc = n; stall = s; flush = f; req = q; D_is_jump = j;
      fetched = m_fpc;
      if (r) begin
         m_fpc = R_PC;
         m_dpc = R_PC; m_dinstr = '0; m_dexc = 5'd0; m_dbd = 1'b0;
      end else if (q) begin
         m_fpc = n;
         m_dpc = H_PC; m_dinstr = '0; m_dexc = 5'd0; m_dbd = 1'b0;
      end else if (s) begin
         // everything holds
      end else begin
         m_fpc = n;
         m_dpc = fetched;
         if (f) begin
            m_dinstr = '0; m_dexc = 5'd0; m_dbd = 1'b0;
         end else begin
            m_dinstr = bad_addr(fetched) ? 32'h0 : (fetched ^ SALT);
            m_dexc   = bad_addr(fetched) ? 5'd4 : 5'd0;
            m_dbd    = j;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check("F_pc",       i_inst_addr,         m_fpc);
      check("D_pc",       D_pc,                m_dpc);
      check("D_instr",    D_instr,             m_dinstr);
      check("D_exc_code", {27'b0, D_exc_code}, {27'b0, m_dexc});
      check("D_bd",       {31'b0, D_bd},       {31'b0, m_dbd});
   endtask

   task automatic run(input logic [31:0] n);
      step(1'b0, n, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] n;
      logic s, f, q, j, r;
      m_fpc = R_PC; m_dpc = R_PC; m_dinstr = '0; m_dexc = '0; m_dbd = 1'b0;
      @(negedge clk);
      step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1);

      // free run from reset
      for (int i = 0; i < 2; i++) run(m_fpc + 32'd4);
      // three-cycle stall at F_pc = 0x3008, then release
      for (int i = 0; i < 3; i++) step(1'b0, m_fpc + 32'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      run(m_fpc + 32'd4);
      check("release_D_pc", D_pc, 32'h0000_3008);

      // misaligned, then above range, then below range
      run(32'h0000_3011);
      run(32'h0000_7000);
      check("adel_misaligned_pc", D_pc, 32'h0000_3011);
      run(32'h0000_2FFC);
      check("adel_hi_pc", D_pc, 32'h0000_7000);
      run(32'h0000_6FFC);
      run(32'h0000_3000);
      check("edge_hi_exc", {27'b0, D_exc_code}, 32'd0);

      // req with stall
      step(1'b0, H_PC, 1'b1, 1'b0, 1'b1, 1'b0);
      check("req_stall_D_pc", D_pc, H_PC);

      // jump in D while fetching 0x3010
      run(32'h0000_3010);
      step(1'b0, 32'h0000_3014, 1'b0, 1'b0, 1'b0, 1'b1);
      check("bd_D_pc", D_pc, 32'h0000_3010);
      check("bd_flag", {31'b0, D_bd}, 32'd1);
      step(1'b0, 32'h0000_3018, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 32'h0000_301C, 1'b1, 1'b1, 1'b0, 1'b0);
      // reset mid-stall / mid-req
      step(1'b1, 32'h0000_5000, 1'b1, 1'b0, 1'b1, 1'b1);

      for (int i = 0; i < 400; i++) begin
         r = ($urandom_range(0, 49) == 0);
         q = ($urandom_range(0, 15) == 0);
         s = ($urandom_range(0, 3) == 0);
         f = ($urandom_range(0, 7) == 0);
         j = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 9))
            0:       n = $urandom;
            1:       n = LO + ($urandom_range(0, 32'h3FFF) << 2);
            2:       n = HI;
            3:       n = HI + 32'd4;
            4:       n = LO - 32'd4;
            5:       n = m_fpc + 32'd1 + $urandom_range(0, 2);
            default: n = m_fpc + 32'd4;
         endcase
         if (q) n = H_PC;
         step(r, n, s, f, q, j);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
